// File: rtl/max7219_chain_ctrl.sv
// MAX7219 daisy-chain controller: runs the init sequence after reset, then rewrites
// config and digit registers on every update request through a built-in SCK shifter.
module max7219_chain_ctrl #(
  parameter int N_DEV      = 1,
  parameter int CLK_DIV    = 4,
  parameter int SCAN_LIMIT = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DEV*64-1:0] seg_data,
  input  logic [7:0]         decode,
  input  logic [3:0]         intensity,
  input  logic               enable,
  input  logic               update,
  output logic               busy,
  output logic               done,
  output logic               max_cs,
  output logic               max_sck,
  output logic               max_din
);

  localparam int          W         = N_DEV * 16;
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(2 * CLK_DIV - 2);
  localparam logic [7:0]  BIT_LAST  = 8'(W - 1);
  localparam logic [7:0]  SCAN_BYTE = 8'(SCAN_LIMIT);

  typedef enum logic [1:0] {SEQ_INIT, SEQ_IDLE, SEQ_UPD} seq_e;
  typedef enum logic [1:0] {FRM_LOAD, FRM_SHIFT, FRM_LATCH, FRM_GAP} frm_e;

  seq_e          r_seq, w_seqNext;
  frm_e          r_frm, w_frmNext;
  logic          r_start, w_startNext;
  logic          r_pending, w_pendingNext;
  logic [3:0]    r_frame, w_frameNext;
  logic [15:0]   r_cnt, w_cntNext;
  logic [7:0]    r_bit, w_bitNext;
  logic [W-1:0]  r_shift, w_shiftNext;
  logic          r_cs, w_csNext;
  logic          r_sck, w_sckNext;
  logic          r_din, w_dinNext;
  logic          r_done, w_doneNext;

  logic [N_DEV*64-1:0] r_seg;
  logic [7:0]          r_dec;
  logic [3:0]          r_int;
  logic                r_en;

  logic [3:0]    w_slot;
  logic [2:0]    w_digitK;
  logic [W-1:0]  w_word;
  logic          w_lastFrame;
  logic          w_capture;

  // Slot numbering follows the init order; update frames skip display-test and scan-limit.
  always_comb begin
    w_slot = r_frame;
    if (r_seq == SEQ_UPD) begin
      case (r_frame)
        4'd0:    w_slot = 4'd1;
        4'd1:    w_slot = 4'd3;
        4'd2:    w_slot = 4'd4;
        default: w_slot = r_frame + 4'd2;
      endcase
    end
    w_digitK = 3'(w_slot - 4'd5);
    w_word   = '0;
    for (int d = 0; d < N_DEV; d++) begin
      case (w_slot)
        4'd0:    w_word[d*16 +: 16] = 16'h0F00;
        4'd1:    w_word[d*16 +: 16] = {8'h0C, 7'h00, r_en};
        4'd2:    w_word[d*16 +: 16] = {8'h0B, SCAN_BYTE};
        4'd3:    w_word[d*16 +: 16] = {8'h09, r_dec};
        4'd4:    w_word[d*16 +: 16] = {8'h0A, 4'h0, r_int};
        default: w_word[d*16 +: 16] = {4'h0, w_slot - 4'd4,
                                       r_seg[(d*8 + int'(w_digitK))*8 +: 8]};
      endcase
    end
    w_lastFrame = (r_seq == SEQ_UPD) ? (r_frame == 4'd10) : (r_frame == 4'd12);
  end

  assign w_capture = (r_seq != SEQ_IDLE) && (r_frm == FRM_LOAD) && r_start;

  always_comb begin
    w_seqNext     = r_seq;
    w_frmNext     = r_frm;
    w_startNext   = r_start;
    w_pendingNext = r_pending;
    w_frameNext   = r_frame;
    w_cntNext     = r_cnt;
    w_bitNext     = r_bit;
    w_shiftNext   = r_shift;
    w_csNext      = r_cs;
    w_sckNext     = r_sck;
    w_dinNext     = r_din;
    w_doneNext    = 1'b0;
    if (r_seq == SEQ_IDLE) begin
      if (update) begin
        w_seqNext   = SEQ_UPD;
        w_frmNext   = FRM_LOAD;
        w_startNext = 1'b1;
        w_frameNext = 4'd0;
      end
    end else begin
      if (update) w_pendingNext = 1'b1;
      case (r_frm)
        FRM_LOAD: begin
          if (r_start) begin
            w_startNext = 1'b0;
          end else begin
            w_shiftNext = w_word;
            w_dinNext   = w_word[W-1];
            w_csNext    = 1'b0;
            w_sckNext   = 1'b0;
            w_cntNext   = '0;
            w_bitNext   = '0;
            w_frmNext   = FRM_SHIFT;
          end
        end
        FRM_SHIFT: begin
          if (r_cnt == DIV_LAST) begin
            w_cntNext = '0;
            if (!r_sck) begin
              w_sckNext = 1'b1;
            end else begin
              w_sckNext = 1'b0;
              if (r_bit == BIT_LAST) begin
                w_frmNext = FRM_LATCH;
                w_dinNext = 1'b0;
              end else begin
                w_bitNext   = r_bit + 8'd1;
                w_shiftNext = {r_shift[W-2:0], 1'b0};
                w_dinNext   = r_shift[W-2];
              end
            end
          end else begin
            w_cntNext = r_cnt + 16'd1;
          end
        end
        FRM_LATCH: begin
          if (r_cnt == DIV_LAST) begin
            w_cntNext = '0;
            w_csNext  = 1'b1;
            w_frmNext = FRM_GAP;
          end else begin
            w_cntNext = r_cnt + 16'd1;
          end
        end
        default: begin
          if (r_cnt == GAP_LAST) begin
            w_cntNext = '0;
            w_frmNext = FRM_LOAD;
            if (w_lastFrame) begin
              // A request seen during the sequence, or on this very clk, chains straight into UPD.
              w_doneNext    = 1'b1;
              w_frameNext   = 4'd0;
              w_pendingNext = 1'b0;
              if (r_pending || update) begin
                w_seqNext   = SEQ_UPD;
                w_startNext = 1'b1;
              end else begin
                w_seqNext = SEQ_IDLE;
              end
            end else begin
              w_frameNext = r_frame + 4'd1;
            end
          end else begin
            w_cntNext = r_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq     <= SEQ_INIT;
      r_frm     <= FRM_LOAD;
      r_start   <= 1'b1;
      r_pending <= 1'b0;
      r_frame   <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      r_din     <= 1'b0;
      r_done    <= 1'b0;
      r_seg     <= '0;
      r_dec     <= '0;
      r_int     <= '0;
      r_en      <= 1'b0;
    end else begin
      r_seq     <= w_seqNext;
      r_frm     <= w_frmNext;
      r_start   <= w_startNext;
      r_pending <= w_pendingNext;
      r_frame   <= w_frameNext;
      r_cnt     <= w_cntNext;
      r_bit     <= w_bitNext;
      r_shift   <= w_shiftNext;
      r_cs      <= w_csNext;
      r_sck     <= w_sckNext;
      r_din     <= w_dinNext;
      r_done    <= w_doneNext;
      if (w_capture) begin
        r_seg <= seg_data;
        r_dec <= decode;
        r_int <= intensity;
        r_en  <= enable;
      end
    end
  end

  assign busy    = (r_seq != SEQ_IDLE);
  assign done    = r_done;
  assign max_cs  = r_cs;
  assign max_sck = r_sck;
  assign max_din = r_din;

endmodule
